// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-driven bus master.
// Command codes and parser state encoding.
package uart_bus_master_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] RSP_OK = 8'h4B;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      WRITE,
      READ,
      RESP
   } state_e;

endpackage

// File: rtl/uart_bus_master_tx.sv
// 8N1 byte transmitter; a new start can be accepted in the
// final stop-bit cycle so frames run back-to-back.
module uart_byte_tx #(
   parameter int BAUDCNT = 48
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       last_o,
   output logic       txd_o
);

   localparam int BW = $clog2(BAUDCNT);

   logic          busy_q, busy_d;
   logic [3:0]    bit_q, bit_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [8:0]    sh_q, sh_d;
   logic          txd_q, txd_d;
   logic          tick;

   assign tick   = (cnt_q == BW'(BAUDCNT - 1));
   assign last_o = busy_q && tick && (bit_q == 4'd9);
   assign busy_o = busy_q;
   assign txd_o  = txd_q;

   always_comb begin
      busy_d = busy_q;
      bit_d  = bit_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      txd_d  = txd_q;
      if (busy_q) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            if (bit_q == 4'd9) begin
               busy_d = 1'b0;
               txd_d  = 1'b1;
            end else begin
               bit_d = bit_q + 4'd1;
               txd_d = sh_q[0];
               sh_d  = {1'b1, sh_q[8:1]};
            end
         end
      end
      if (start_i && (!busy_q || last_o)) begin
         busy_d = 1'b1;
         bit_d  = 4'd0;
         cnt_d  = '0;
         txd_d  = 1'b0;
         sh_d   = {1'b1, data_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         bit_q  <= 4'd0;
         cnt_q  <= '0;
         sh_q   <= 9'h1FF;
         txd_q  <= 1'b1;
      end else begin
         busy_q <= busy_d;
         bit_q  <= bit_d;
         cnt_q  <= cnt_d;
         sh_q   <= sh_d;
         txd_q  <= txd_d;
      end
   end

endmodule

// File: rtl/uart_bus_master.sv
// Serial command bridge: parses 'W'/'R' frames from RXD and
// issues single 32-bit bus cycles, answering on TXD.
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter int BAUDCNT = 48,
   parameter int TIMEOUT = 480000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rxd_i,
   output logic        txd_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   input  logic [31:0] m_data_i,
   output logic        m_rd_o,
   output logic        m_wr_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int BW = $clog2(BAUDCNT);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    sync_q;
   logic          rxs;
   logic          rx_act_q;
   logic [BW-1:0] rx_cnt_q;
   logic [3:0]    rx_bit_q;
   logic [7:0]    rx_sh_q;
   logic          rx_vld_q, rx_ferr_q;

   assign rxs = sync_q[1];

   // Start is qualified by half a bit of low, so samples land mid-bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q    <= 2'b11;
         rx_act_q  <= 1'b0;
         rx_cnt_q  <= '0;
         rx_bit_q  <= 4'd0;
         rx_sh_q   <= 8'h00;
         rx_vld_q  <= 1'b0;
         rx_ferr_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rxd_i};
         rx_vld_q  <= 1'b0;
         rx_ferr_q <= 1'b0;
         if (!rx_act_q) begin
            if (rxs) begin
               rx_cnt_q <= '0;
            end else if (rx_cnt_q == BW'(BAUDCNT / 2 - 1)) begin
               rx_act_q <= 1'b1;
               rx_cnt_q <= '0;
               rx_bit_q <= 4'd0;
            end else begin
               rx_cnt_q <= rx_cnt_q + 1'b1;
            end
         end else if (rx_cnt_q == BW'(BAUDCNT - 1)) begin
            rx_cnt_q <= '0;
            if (rx_bit_q == 4'd8) begin
               rx_act_q  <= 1'b0;
               rx_vld_q  <= rxs;
               rx_ferr_q <= !rxs;
            end else begin
               rx_sh_q  <= {rxs, rx_sh_q[7:1]};
               rx_bit_q <= rx_bit_q + 4'd1;
            end
         end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
         end
      end
   end

   state_e        state_q, state_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic          is_wr_q, is_wr_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   rsp_q, rsp_d;
   logic [2:0]    left_q, left_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tx_start, tx_busy, tx_last, tx_ready;
   logic          in_cmd;

   assign in_cmd   = (state_q == ADDR) || (state_q == DATA);
   assign tx_ready = !tx_busy || tx_last;

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rsp_d    = rsp_q;
      left_d   = left_q;
      err_d    = err_q || rx_ferr_q;
      tx_start = 1'b0;
      tmo_d    = (rx_vld_q || rx_ferr_q || !in_cmd) ? '0 : tmo_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (rx_vld_q && (rx_sh_q == CMD_WR || rx_sh_q == CMD_RD)) begin
               state_d = ADDR;
               bcnt_d  = 2'd0;
               is_wr_d = (rx_sh_q == CMD_WR);
            end
         end
         ADDR: begin
            if (rx_ferr_q) begin
               state_d = IDLE;
            end else if (rx_vld_q) begin
               addr_d = {addr_q[23:0], rx_sh_q};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) state_d = is_wr_q ? DATA : READ;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         DATA: begin
            if (rx_ferr_q) begin
               state_d = IDLE;
            end else if (rx_vld_q) begin
               data_d = {data_q[23:0], rx_sh_q};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) state_d = WRITE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         WRITE: begin
            rsp_d   = {RSP_OK, 24'h000000};
            left_d  = 3'd1;
            state_d = RESP;
         end
         READ: begin
            rsp_d   = m_data_i;
            left_d  = 3'd4;
            state_d = RESP;
         end
         RESP: begin
            if (left_q != 3'd0) begin
               if (tx_ready) begin
                  tx_start = 1'b1;
                  rsp_d    = {rsp_q[23:0], 8'h00};
                  left_d   = left_q - 3'd1;
               end
            end else if (tx_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         bcnt_q  <= 2'd0;
         is_wr_q <= 1'b0;
         addr_q  <= 32'h0;
         data_q  <= 32'h0;
         rsp_q   <= 32'h0;
         left_q  <= 3'd0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rsp_q   <= rsp_d;
         left_q  <= left_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   uart_byte_tx #(.BAUDCNT(BAUDCNT)) u_tx (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (tx_start),
      .data_i  (rsp_q[31:24]),
      .busy_o  (tx_busy),
      .last_o  (tx_last),
      .txd_o   (txd_o)
   );

   assign m_addr_o = addr_q;
   assign m_data_o = data_q;
   assign m_wr_o   = (state_q == WRITE);
   assign m_rd_o   = (state_q == READ);
   assign busy_o   = (state_q != IDLE);
   assign err_o    = err_q;

endmodule
